// File: rtl/pic_pkg.sv
// Shared constants, FSM state type and pixel-position helper for the
// picture ROM reader.
package pic_pkg;

  localparam int NUM_PIX    = 784;  // 28 x 28 pixels per frame
  localparam int IMG_W      = 28;   // pixels per row
  localparam int PIX_ADDR_W = 10;   // ROM address width
  localparam int PIX_W      = 8;    // pixel width
  localparam int POS_W      = 5;    // row / column index width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pic_state_e;

  typedef struct packed {
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
  } pix_pos_t;

  // Raster-order successor of a pixel position: column wraps at the end of
  // a row and carries into the row index.
  function automatic pix_pos_t next_pos(input pix_pos_t pos, input int img_w);
    pix_pos_t nxt;
    nxt = pos;
    if (pos.col == POS_W'(img_w - 1)) begin
      nxt.col = '0;
      nxt.row = pos.row + 1'b1;
    end else begin
      nxt.col = pos.col + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pic_skid_fifo.sv
// Small synchronous FIFO that absorbs ROM returns while the downstream
// stream is stalled. Any depth (not only powers of two) is supported.
module pic_skid_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rd_en = pop && !empty;
  // A full FIFO may still accept a write in the same cycle its head leaves.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the storage array has no reset; an entry is only observable after
  // it has been written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pic_reader.sv
// Read-side initiator for the 28x28 picture ROM: walks addresses 0..783,
// absorbs the ROM read latency and presents pixels as a valid/ready stream
// tagged with row, column and last-pixel flag.
module pic_reader #(
  parameter int NUM_PIX    = pic_pkg::NUM_PIX,
  parameter int IMG_W      = pic_pkg::IMG_W,
  parameter int ADDR_W     = pic_pkg::PIX_ADDR_W,
  parameter int DATA_W     = pic_pkg::PIX_W,
  parameter int RAM_LAT    = 1,
  parameter int FIFO_DEPTH = RAM_LAT + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [4:0]        pix_row,
  output logic [4:0]        pix_col,
  output logic              pix_last
);

  import pic_pkg::*;

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W   = CNT_W + 2;
  localparam int ENTRY_W = 1 + 2 * POS_W + DATA_W;

  pic_state_e        state;
  pic_state_e        state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [RAM_LAT-1:0] rd_vld_sr;   // bit RAM_LAT-1 lines up with ram_data
  logic [ADDR_W-1:0] tag_cnt;
  pix_pos_t          tag_pos;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [OCC_W-1:0]  occupancy;
  logic              issue;
  logic              frame_start;
  logic              push;
  logic              pop;
  logic              tag_last;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign push     = rd_vld_sr[RAM_LAT-1];
  assign pop      = !fifo_empty && pix_ready;
  assign tag_last = (tag_cnt == ADDR_W'(NUM_PIX - 1));

  // Entries already in the FIFO plus reads still in flight; the current
  // pop is deliberately left out so pix_ready never reaches ram_en.
  always_comb begin
    occupancy = OCC_W'(fifo_count);
    for (int i = 0; i < RAM_LAT; i++) begin
      occupancy = occupancy + OCC_W'(rd_vld_sr[i]);
    end
  end

  // Next-state and read-issue decode.
  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = ISSUE;
          frame_start = 1'b1;
        end
      end
      ISSUE: begin
        if (occupancy < OCC_W'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (rd_ptr == ADDR_W'(NUM_PIX - 1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && pix_last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Read pointer: restarts at 0 per frame and parks on the final address
  // rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      rd_ptr <= '0;
    end else if (issue && (rd_ptr != ADDR_W'(NUM_PIX - 1))) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // In-flight tracker; clearing it on reset drops any read still returning.
  always_ff @(posedge clk) begin
    if (rst) rd_vld_sr <= '0;
    else     rd_vld_sr <= RAM_LAT'({rd_vld_sr, issue});
  end

  // Raster position of the next pixel to enter the FIFO.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      tag_cnt <= '0;
      tag_pos <= '0;
    end else if (push) begin
      tag_cnt <= tag_cnt + 1'b1;
      tag_pos <= next_pos(tag_pos, IMG_W);
    end
  end

  assign push_entry = {tag_last, tag_pos.row, tag_pos.col, ram_data};

  pic_skid_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Stream outputs are forced to zero while the FIFO is empty so nothing
  // from unwritten storage leaks out.
  assign pix_valid = !fifo_empty;
  assign {pix_last, pix_row, pix_col, pix_data} = fifo_empty ? '0 : head_entry;

  assign ram_en   = issue;
  assign ram_addr = rd_ptr;
  assign busy     = (state == ISSUE) || (state == DRAIN);
  assign done     = (state == DONE);

endmodule
